// File: rtl/rr_encoder8.sv
// rr_encoder8: eight request lines in, one registered 3-bit winner index out.
// A winner keeps the slot until it raises done. The next search then starts
// one position past that winner, so every requester gets a turn.
// With ROUND_ROBIN=0 the search always starts at bit 0 (fixed priority).
module rr_encoder8 #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       grant_valid,
  output logic [2:0] grant_idx
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] ptr;
  logic [2:0] ptr_nxt;
  logic [2:0] idx_nxt;
  logic       vld_nxt;
  logic [2:0] search_start;
  logic [2:0] winner;
  logic       any_req;

  // First set bit of r, scanning upward from start and wrapping 7 -> 0.
  // The result is only used when r is non-zero.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] pick;
    logic [2:0] pos;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pos = start + 3'(i);
      if (!found && r[pos]) begin
        pick  = pos;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Pointer after a release: one past the owner, modulo 8. Fixed priority pins it to 0.
  function automatic logic [2:0] ptr_after(input logic [2:0] owner);
    if (ROUND_ROBIN) begin
      return owner + 3'd1;
    end
    return 3'd0;
  endfunction

  assign any_req      = |req;
  assign search_start = ROUND_ROBIN ? ptr : 3'd0;
  assign winner       = rr_pick(req, search_start);

  // Next-state logic: arbitrate in IDLE, hold the owner in GRANT until done
  always_comb begin
    state_nxt = state;
    vld_nxt   = grant_valid;
    idx_nxt   = grant_idx;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = GRANT;
          vld_nxt   = 1'b1;
          idx_nxt   = winner;
        end
      end
      GRANT: begin
        if (done) begin
          state_nxt = IDLE;
          vld_nxt   = 1'b0;
          ptr_nxt   = ptr_after(grant_idx);
        end
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
      end
    endcase
  end

  // State and output registers; the outputs come only from these flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= 3'd0;
      ptr         <= 3'd0;
    end else begin
      state       <= state_nxt;
      grant_valid <= vld_nxt;
      grant_idx   <= idx_nxt;
      ptr         <= ROUND_ROBIN ? ptr_nxt : 3'd0;
    end
  end

endmodule

// File: tb/tb_rr_encoder8.sv
// Bench for rr_encoder8: one rotating-priority instance and one fixed-priority
// instance. The stimulus pushes each expected winner into a queue; a monitor
// per instance pops an entry on each new grant and checks the index on every
// valid cycle.
module tb_rr_encoder8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       gv;
  logic [2:0] gi;

  logic       rst2_n;
  logic [7:0] req2;
  logic       done2;
  logic       gv2;
  logic [2:0] gi2;

  int n_chk  = 0;
  int n_fail = 0;

  int exp_q[$];
  int exp2_q[$];

  always #5 clk = ~clk;

  rr_encoder8 #(.ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant_valid(gv), .grant_idx(gi)
  );

  rr_encoder8 #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst2_n), .req(req2), .done(done2),
    .grant_valid(gv2), .grant_idx(gi2)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs change here, away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample the outputs on the falling edge of the current cycle
  task automatic chk_out(input string name, input int exp_v, input int exp_i);
    @(negedge clk);
    chk({name, "_valid"}, int'(gv), exp_v);
    if (exp_i >= 0) chk({name, "_idx"}, int'(gi), exp_i);
  endtask

  // Monitor for the rotating instance
  logic prev_v  = 1'b0;
  int   cur_exp = 0;
  always @(negedge clk) begin
    if (gv === 1'b1) begin
      if (prev_v !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rr_unexpected_grant: got idx %0d expected no grant", gi);
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      chk("rr_grant_idx", int'(gi), cur_exp);
    end
    prev_v = gv;
  end

  // Monitor for the fixed-priority instance
  logic prev_v2  = 1'b0;
  int   cur_exp2 = 0;
  always @(negedge clk) begin
    if (gv2 === 1'b1) begin
      if (prev_v2 !== 1'b1) begin
        if (exp2_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL fp_unexpected_grant: got idx %0d expected no grant", gi2);
        end else begin
          cur_exp2 = exp2_q.pop_front();
        end
      end
      chk("fp_grant_idx", int'(gi2), cur_exp2);
    end
    prev_v2 = gv2;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0; req  = 8'hFF; done  = 1'b1;
    rst2_n = 1'b0; req2 = 8'h00; done2 = 1'b0;

    // Reset held for two edges with every request and done high
    tick(); chk_out("reset1", 0, 0);
    tick(); chk_out("reset2", 0, 0);
    rst_n = 1'b1; done = 1'b0;
    exp_q.push_back(0);
    tick(); chk_out("post_reset", 1, 0);
    req = 8'h00; done = 1'b1;
    tick(); chk_out("post_reset_rel", 0, -1);

    // Basic grant, hold, release, rotate (restart from a clean pointer)
    rst_n = 1'b0; done = 1'b0;
    tick(); chk_out("reset3", 0, 0);
    rst_n = 1'b1; req = 8'b0010_0100;
    exp_q.push_back(2);
    tick(); chk_out("basic_grant", 1, 2);
    for (int k = 0; k < 5; k++) begin
      tick(); chk_out("basic_hold", 1, 2);
    end
    done = 1'b1;
    tick(); chk_out("basic_bubble", 0, -1);
    done = 1'b0;
    exp_q.push_back(5);
    tick(); chk_out("basic_rotate", 1, 5);
    done = 1'b1; req = 8'h00;
    tick(); chk_out("basic_rel", 0, -1);

    // Wrap-around: 7 then pointer 0, then 0, then 7
    done = 1'b0; req = 8'h80;
    exp_q.push_back(7);
    tick(); chk_out("wrap_g7", 1, 7);
    done = 1'b1; req = 8'b1000_0001;
    tick(); chk_out("wrap_rel7", 0, 7);
    done = 1'b0;
    exp_q.push_back(0);
    tick(); chk_out("wrap_g0", 1, 0);
    done = 1'b1;
    tick(); chk_out("wrap_rel0", 0, -1);
    done = 1'b0;
    exp_q.push_back(7);
    tick(); chk_out("wrap_g7b", 1, 7);
    done = 1'b1; req = 8'hFF;
    tick(); chk_out("wrap_rel7b", 0, -1);

    // Fairness sweep from pointer 0 with all requests held
    for (int k = 0; k < 9; k++) begin
      done = 1'b0;
      exp_q.push_back(k % 8);
      tick(); chk_out("sweep_grant", 1, k % 8);
      done = 1'b1;
      tick(); chk_out("sweep_bubble", 0, -1);
    end
    done = 1'b0; req = 8'h00;

    // Request drop while granted, then reset mid-grant
    rst_n = 1'b0;
    tick(); chk_out("reset4", 0, 0);
    rst_n = 1'b1; req = 8'b0000_1000;
    exp_q.push_back(3);
    tick(); chk_out("drop_grant", 1, 3);
    req = 8'h00;
    tick(); chk_out("drop_persist", 1, 3);
    tick(); chk_out("drop_persist2", 1, 3);
    rst_n = 1'b0; done = 1'b1;
    tick(); chk_out("midgrant_reset", 0, 0);
    rst_n = 1'b1; done = 1'b0; req = 8'b0000_1000;
    exp_q.push_back(3);
    tick(); chk_out("after_reset_grant", 1, 3);
    done = 1'b1; req = 8'h00;
    tick(); chk_out("final_rel", 0, -1);
    done = 1'b0;

    // Fixed priority: bit 0 always beats bit 7
    tick();
    rst2_n = 1'b1; req2 = 8'b1000_0001;
    for (int k = 0; k < 4; k++) begin
      done2 = 1'b0;
      exp2_q.push_back(0);
      tick();
      @(negedge clk);
      chk("fp_valid", int'(gv2), 1);
      chk("fp_idx", int'(gi2), 0);
      done2 = 1'b1;
      tick();
      @(negedge clk);
      chk("fp_bubble", int'(gv2), 0);
    end
    done2 = 1'b0; req2 = 8'h00;
    tick(); tick();

    chk("rr_queue_drained", exp_q.size(), 0);
    chk("fp_queue_drained", exp2_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_encoder8.md
# rr_encoder8

8-input round-robin request encoder: the reverse of the 3-to-8 select decoder. It takes eight one-bit request lines, picks one winner, and presents it as a registered 3-bit index with a valid flag. The winner is held until the owner signals completion. It sits in front of shared datapath resources (memory port, bus driver), where several units compete for one slot and the downstream select logic consumes a binary index.

## Interface
- ROUND_ROBIN, default 1: 1 selects rotating priority; 0 selects fixed priority, where the lowest index always wins.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  8  request vector; bit i high means requester i wants the resource.
- done  in  1  current owner releases the grant. Sampled only in GRANT.
- grant_valid  out  1  a grant is active (registered).
- grant_idx  out  3  binary index of the current owner (registered). Meaningful only while grant_valid=1.

## Operation
- Internal state:
  - 2-state FSM: IDLE, GRANT.
  - 3-bit priority pointer ptr.
- Reset (rst_n=0 at a clock edge):
  - FSM goes to IDLE.
  - grant_valid=0, grant_idx=0, ptr=0.
  - Reset takes precedence over all other inputs, including mid-grant.
- IDLE:
  - If req==0: stay in IDLE; outputs unchanged (grant_valid stays 0).
  - If req!=0: search from bit ptr upward, wrapping 7->0. The first set bit is the winner.
  - On the next edge: grant_idx=winner, grant_valid=1, FSM goes to GRANT.
  - done is ignored in IDLE.
- GRANT:
  - grant_idx and grant_valid are held stable.
  - req is ignored, including the owner's own req bit dropping; the grant persists until done.
  - On done=1 at an edge: grant_valid=0, FSM goes to IDLE, ptr=grant_idx+1 (3-bit wrap, so 7 becomes 0).
  - grant_idx keeps its last value after release.
- ROUND_ROBIN=0: ptr is forced to 0 at all times, so the search always starts at bit 0.
- Arithmetic: ptr and the search index are 3-bit modulo-8 values; there is no out-of-range case.

## Timing
- Request to grant: req seen in IDLE at edge N gives grant_valid=1 and a valid grant_idx after edge N, i.e. 1-cycle latency.
- done to release: done seen at edge M gives grant_valid=0 after edge M.
- Minimum bubble: one cycle with grant_valid=0 between consecutive grants. The next arbitration happens in IDLE at edge M+1 using the updated ptr.
- Grant duration: at least 1 cycle (done may be high on the first GRANT cycle).
- Simultaneous events:
  - done=1 together with new req changes: the release wins; new requests are arbitrated in the following IDLE cycle.
  - rst_n=0 together with done or req: reset wins.
- Outputs come straight from registers, with no combinational path from req or done to the outputs.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req=8'hFF and done=1 -> grant_valid=0 and grant_idx=0 throughout. Release reset -> next edge gives grant_valid=1, grant_idx=0.
- Basic grant/hold/rotate: from reset, req=8'b0010_0100 -> next cycle grant_idx=2, valid=1. Keep done=0 for 5 cycles -> idx stays 2. Pulse done=1 -> valid=0 for one cycle, then grant_idx=5.
- Wrap-around: after a grant to 7 is released (ptr=0), req=8'b1000_0001 -> grant_idx=0. Release it -> grant_idx=7.
- Fairness sweep: req=8'hFF held, done pulsed on each GRANT cycle -> grant_idx sequence 0,1,2,...,7,0 with exactly one grant_valid=0 cycle between grants.
- Fixed priority (ROUND_ROBIN=0): req=8'b1000_0001 held, done pulsed on every grant -> grant_idx is always 0; 7 is never granted.
- Reset mid-grant and request drop:
  - In GRANT with idx=3, drop req[3] -> grant persists.
  - Assert rst_n=0 -> next edge gives grant_valid=0, grant_idx=0.
  - Apply req=8'b0000_1000 -> grant_idx=3 one cycle after reset release.
